// File: rtl/microwave_pkg.sv
// Shared state codes, BCD limits and the keypad acceptance rule for the
// microwave cook sequencer.
package microwave_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ENTRY = 3'd1,
      COOK  = 3'd2,
      PAUSE = 3'd3,
      DONE  = 3'd4
   } state_e;

   localparam logic [3:0] BCD_ONES_MAX = 4'd9;
   localparam logic [3:0] BCD_TENS_MAX = 4'd5;
   localparam logic [1:0] MAX_DIGITS   = 2'd3;

   // A digit is taken only if it is BCD, there is room for it, and the
   // current ones digit can legally move into the seconds-tens position.
   function automatic logic key_accepted(input logic [3:0] code,
                                         input logic [3:0] ones,
                                         input logic [1:0] cnt);
      return (code <= BCD_ONES_MAX) && (ones <= BCD_TENS_MAX) && (cnt != MAX_DIGITS);
   endfunction

endpackage

// File: rtl/cook_sequencer_tick_prescaler.sv
// Divides the system clock down to the one-second tick. The counter can be
// cleared, advanced or held, so a paused cook keeps its tick phase.
module tick_prescaler #(
   parameter int unsigned CLK_DIV = 100
) (
   input  logic clk_i,
   input  logic clrn_i,
   input  logic clr_i,
   input  logic run_i,
   output logic tick_o,
   output logic tick_next_o
);

   localparam int unsigned W    = $clog2(CLK_DIV);
   localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

   logic [W-1:0] count_q, count_d;
   logic         tick_q;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (run_i) begin
         count_d = (count_q == LAST) ? '0 : count_q + W'(1);
      end
   end

   // tick_o is high exactly while the registered count sits at its last value.
   always_ff @(posedge clk_i or negedge clrn_i) begin
      if (!clrn_i) begin
         count_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         tick_q  <= (count_d == LAST);
      end
   end

   assign tick_o      = tick_q;
   assign tick_next_o = (count_d == LAST);

endmodule

// File: rtl/cook_sequencer.sv
// Microwave session controller: keypad digit entry, timer load/clear,
// one-second count enables, magnetron gating, door interlock and end beep.
module cook_sequencer
   import microwave_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 100,
   parameter int unsigned BEEP_TICKS = 3
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       startn,
   input  logic       stopn,
   input  logic       door_closed,
   input  logic       timer_zero,
   output logic [3:0] preset_min,
   output logic [3:0] preset_tens,
   output logic [3:0] preset_ones,
   output logic       loadn,
   output logic       timer_clrn,
   output logic       count_en,
   output logic       mag_on,
   output logic       beep,
   output logic [2:0] state
);

   localparam int unsigned  BW        = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;
   localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_TICKS - 1);

   logic       key_s_q, key_q, startn_s_q, startn_q, stopn_s_q, stopn_q;
   logic       door_s_q, tz_s_q;
   logic [3:0] code_s_q;
   logic       key_edge, start_edge, stop_edge;

   state_e     state_q, state_d;
   logic [3:0] min_q, min_d, tens_q, tens_d, ones_q, ones_d;
   logic [1:0] cnt_q, cnt_d;
   logic [BW-1:0] beep_cnt_q, beep_cnt_d;
   logic       loadn_q, timer_clrn_q, count_en_q, mag_q, beep_q;

   logic       load_pulse, clear_pulse, clear_presets;
   logic       presc_clr, presc_run, presc_tick, presc_tick_next;

   // One sampling stage on every input; edges compare it with the prior sample.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         key_s_q    <= 1'b0;
         key_q      <= 1'b0;
         code_s_q   <= '0;
         startn_s_q <= 1'b1;
         startn_q   <= 1'b1;
         stopn_s_q  <= 1'b1;
         stopn_q    <= 1'b1;
         door_s_q   <= 1'b0;
         tz_s_q     <= 1'b0;
      end else begin
         key_s_q    <= key_valid;
         key_q      <= key_s_q;
         code_s_q   <= key_code;
         startn_s_q <= startn;
         startn_q   <= startn_s_q;
         stopn_s_q  <= stopn;
         stopn_q    <= stopn_s_q;
         door_s_q   <= door_closed;
         tz_s_q     <= timer_zero;
      end
   end

   assign key_edge   = key_s_q & ~key_q;
   assign start_edge = ~startn_s_q & startn_q;
   assign stop_edge  = ~stopn_s_q & stopn_q;

   always_comb begin
      state_d       = state_q;
      min_d         = min_q;
      tens_d        = tens_q;
      ones_d        = ones_q;
      cnt_d         = cnt_q;
      beep_cnt_d    = beep_cnt_q;
      load_pulse    = 1'b0;
      clear_pulse   = 1'b0;
      clear_presets = 1'b0;
      presc_clr     = 1'b0;

      case (state_q)
         IDLE, ENTRY: begin
            if (stop_edge) begin
               if (state_q == ENTRY) begin
                  state_d       = IDLE;
                  clear_presets = 1'b1;
                  clear_pulse   = 1'b1;
               end
            end else if (state_q == ENTRY && start_edge && door_s_q &&
                         (|{min_q, tens_q, ones_q})) begin
               state_d    = COOK;
               load_pulse = 1'b1;
               presc_clr  = 1'b1;
            end else if (key_edge && key_accepted(code_s_q, ones_q, cnt_q)) begin
               min_d   = tens_q;
               tens_d  = ones_q;
               ones_d  = code_s_q;
               cnt_d   = cnt_q + 2'd1;
               state_d = ENTRY;
            end
         end
         COOK: begin
            // The load cycle still shows the old timer contents, so zero is ignored there.
            if (stop_edge || !door_s_q) begin
               state_d = PAUSE;
            end else if (tz_s_q && loadn_q) begin
               state_d    = DONE;
               presc_clr  = 1'b1;
               beep_cnt_d = '0;
            end
         end
         PAUSE: begin
            if (stop_edge) begin
               state_d       = IDLE;
               clear_presets = 1'b1;
               clear_pulse   = 1'b1;
            end else if (start_edge && door_s_q) begin
               state_d = COOK;
            end
         end
         DONE: begin
            if (stop_edge) begin
               state_d       = IDLE;
               clear_presets = 1'b1;
            end else if (presc_tick && beep_cnt_q == BEEP_LAST) begin
               state_d       = IDLE;
               clear_presets = 1'b1;
            end else if (presc_tick) begin
               beep_cnt_d = beep_cnt_q + BW'(1);
            end
         end
         default: begin
            state_d       = IDLE;
            clear_presets = 1'b1;
         end
      endcase

      if (clear_presets) begin
         min_d  = '0;
         tens_d = '0;
         ones_d = '0;
         cnt_d  = '0;
      end

      presc_run = (state_d == COOK) || (state_d == DONE);
   end

   tick_prescaler #(
      .CLK_DIV(CLK_DIV)
   ) u_prescaler (
      .clk_i       (clk),
      .clrn_i      (clrn),
      .clr_i       (presc_clr),
      .run_i       (presc_run),
      .tick_o      (presc_tick),
      .tick_next_o (presc_tick_next)
   );

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q      <= IDLE;
         min_q        <= '0;
         tens_q       <= '0;
         ones_q       <= '0;
         cnt_q        <= '0;
         beep_cnt_q   <= '0;
         loadn_q      <= 1'b1;
         timer_clrn_q <= 1'b1;
         count_en_q   <= 1'b0;
         mag_q        <= 1'b0;
         beep_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         min_q        <= min_d;
         tens_q       <= tens_d;
         ones_q       <= ones_d;
         cnt_q        <= cnt_d;
         beep_cnt_q   <= beep_cnt_d;
         loadn_q      <= ~load_pulse;
         timer_clrn_q <= ~clear_pulse;
         count_en_q   <= (state_d == COOK) && presc_tick_next;
         mag_q        <= (state_d == COOK);
         beep_q       <= (state_d == DONE);
      end
   end

   assign preset_min  = min_q;
   assign preset_tens = tens_q;
   assign preset_ones = ones_q;
   assign loadn       = loadn_q;
   assign timer_clrn  = timer_clrn_q;
   assign count_en    = count_en_q;
   assign mag_on      = mag_q;
   assign beep        = beep_q;
   assign state       = state_q;

endmodule

// File: tb/tb_cook_sequencer.sv
// Randomised bench for cook_sequencer against a session-level reference model
// (entered digit list, cook-second and beep-cycle counters).
module tb_cook_sequencer;

   localparam int CLK_DIV    = 10;
   localparam int BEEP_TICKS = 2;
   localparam int W          = 20;
   localparam int S_IDLE = 0, S_ENTRY = 1, S_COOK = 2, S_PAUSE = 3, S_DONE = 4;
   localparam logic [W-1:0] RESET_VEC = {3'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

   logic       clk = 1'b0;
   logic       clrn, key_valid, startn, stopn, door_closed, timer_zero;
   logic [3:0] key_code;
   logic [3:0] preset_min, preset_tens, preset_ones;
   logic       loadn, timer_clrn, count_en, mag_on, beep;
   logic [2:0] state;
   logic [W-1:0] dut_vec, exp_v;

   int vectors     = 0;
   int miscompares = 0;
   logic [W-1:0] exp_q[$];

   always #5 clk = ~clk;

   cook_sequencer #(
      .CLK_DIV    (CLK_DIV),
      .BEEP_TICKS (BEEP_TICKS)
   ) dut (
      .clk         (clk),
      .clrn        (clrn),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .startn      (startn),
      .stopn       (stopn),
      .door_closed (door_closed),
      .timer_zero  (timer_zero),
      .preset_min  (preset_min),
      .preset_tens (preset_tens),
      .preset_ones (preset_ones),
      .loadn       (loadn),
      .timer_clrn  (timer_clrn),
      .count_en    (count_en),
      .mag_on      (mag_on),
      .beep        (beep),
      .state       (state)
   );

   assign dut_vec = {state, preset_min, preset_tens, preset_ones,
                     loadn, timer_clrn, count_en, mag_on, beep};

   // ---------------- reference model ----------------
   int   m_mode;
   int   digits[$];
   int   cook_cycles, done_cycles;
   logic m_loadn, m_tclrn;
   logic s_key, p_key, s_startn, p_startn, s_stopn, p_stopn, s_door, s_tz;
   logic [3:0] s_code;

   function automatic int digit_at(input int from_right);
      int n;
      n = digits.size();
      return (n > from_right) ? digits[n - 1 - from_right] : 0;
   endfunction

   function automatic int preset_secs();
      return digit_at(2) * 60 + digit_at(1) * 10 + digit_at(0);
   endfunction

   function automatic bit key_ok(input logic [3:0] code);
      if (digits.size() >= 3 || code > 4'd9) return 1'b0;
      if (digits.size() > 0 && digits[digits.size() - 1] > 5) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [W-1:0] model_vec();
      logic cen;
      cen = (m_mode == S_COOK) && (cook_cycles % CLK_DIV == 0);
      return {3'(m_mode), 4'(digit_at(2)), 4'(digit_at(1)), 4'(digit_at(0)),
              m_loadn, m_tclrn, cen, (m_mode == S_COOK), (m_mode == S_DONE)};
   endfunction

   task automatic model_reset();
      m_mode = S_IDLE;
      digits.delete();
      cook_cycles = 0;
      done_cycles = 0;
      m_loadn = 1'b1;
      m_tclrn = 1'b1;
      s_key = 1'b0; p_key = 1'b0; s_code = 4'd0;
      s_startn = 1'b1; p_startn = 1'b1;
      s_stopn = 1'b1; p_stopn = 1'b1;
      s_door = 1'b0; s_tz = 1'b0;
   endtask

   task automatic model_step();
      logic stop_e, start_e, key_e, cur_loadn;
      int   nxt;
      stop_e    = !s_stopn && p_stopn;
      start_e   = !s_startn && p_startn;
      key_e     = s_key && !p_key;
      cur_loadn = m_loadn;
      nxt       = m_mode;
      m_loadn   = 1'b1;
      m_tclrn   = 1'b1;
      case (m_mode)
         S_IDLE, S_ENTRY: begin
            if (stop_e) begin
               if (m_mode == S_ENTRY) begin
                  nxt = S_IDLE; digits.delete(); m_tclrn = 1'b0;
               end
            end else if (m_mode == S_ENTRY && start_e && s_door && preset_secs() != 0) begin
               nxt = S_COOK; m_loadn = 1'b0; cook_cycles = 0;
            end else if (key_e && key_ok(s_code)) begin
               digits.push_back(int'(s_code)); nxt = S_ENTRY;
            end
         end
         S_COOK: begin
            if (stop_e || !s_door) nxt = S_PAUSE;
            else if (s_tz && cur_loadn) begin
               nxt = S_DONE; done_cycles = 0;
            end
         end
         S_PAUSE: begin
            if (stop_e) begin
               nxt = S_IDLE; digits.delete(); m_tclrn = 1'b0;
            end else if (start_e && s_door) nxt = S_COOK;
         end
         S_DONE: begin
            if (stop_e || done_cycles == CLK_DIV * BEEP_TICKS) begin
               nxt = S_IDLE; digits.delete();
            end
         end
         default: nxt = S_IDLE;
      endcase
      m_mode = nxt;
      if (m_mode == S_COOK) cook_cycles++;
      if (m_mode == S_DONE) done_cycles++;
      p_key = s_key;       s_key = key_valid;   s_code = key_code;
      p_startn = s_startn; s_startn = startn;
      p_stopn = s_stopn;   s_stopn = stopn;
      s_door = door_closed; s_tz = timer_zero;
   endtask

   always @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         model_reset();
         exp_q.delete();
         exp_q.push_back(model_vec());
      end else begin
         model_step();
         exp_q.push_back(model_vec());
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         vectors++;
         if (dut_vec !== exp_v) begin
            miscompares++;
            $display("FAIL out_vec t=%0t got st=%0d %0d:%0d%0d ld=%b clr=%b ce=%b mag=%b bp=%b exp st=%0d %0d:%0d%0d ld=%b clr=%b ce=%b mag=%b bp=%b",
                     $time, dut_vec[19:17], dut_vec[16:13], dut_vec[12:9], dut_vec[8:5],
                     dut_vec[4], dut_vec[3], dut_vec[2], dut_vec[1], dut_vec[0],
                     exp_v[19:17], exp_v[16:13], exp_v[12:9], exp_v[8:5],
                     exp_v[4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic press_key(input logic [3:0] code, input int width);
      key_code = code; key_valid = 1'b1; cycles(width);
      key_valid = 1'b0; cycles(2);
   endtask

   task automatic press_start(input int width);
      startn = 1'b0; cycles(width); startn = 1'b1; cycles(2);
   endtask

   task automatic press_stop(input int width);
      stopn = 1'b0; cycles(width); stopn = 1'b1; cycles(2);
   endtask

   task automatic press_both();
      startn = 1'b0; stopn = 1'b0; cycles(1);
      startn = 1'b1; stopn = 1'b1; cycles(2);
   endtask

   task automatic pulse_tz(input int width);
      timer_zero = 1'b1; cycles(width); timer_zero = 1'b0; cycles(1);
   endtask

   task automatic async_reset_check();
      @(posedge clk); #2;
      clrn = 1'b0;
      #1;
      vectors++;
      if (dut_vec !== RESET_VEC) begin
         miscompares++;
         $display("FAIL async_reset got %h exp %h", dut_vec, RESET_VEC);
      end
      cycles(2);
      clrn = 1'b1;
      cycles(2);
   endtask

   initial begin
      clrn = 1'b0; key_valid = 1'b0; key_code = 4'd0;
      startn = 1'b1; stopn = 1'b1; door_closed = 1'b1; timer_zero = 1'b0;
      cycles(3);
      clrn = 1'b1;
      cycles(3);

      // 1:30 cook, door-open pause, resume, end of cook with beep
      press_key(4'd1, 1); press_key(4'd3, 2); press_key(4'd0, 1);
      press_start(1);
      cycles(35);
      door_closed = 1'b0; cycles(6);
      door_closed = 1'b1; cycles(3);
      press_start(2);
      cycles(17);
      pulse_tz(1);
      cycles(25);

      // second digit rejected because 7 cannot become seconds-tens
      press_key(4'd7, 1); press_key(4'd2, 1);
      press_stop(1);

      // fourth digit and non-BCD code rejected, then start+stop together
      press_key(4'd1, 1); press_key(4'd2, 1); press_key(4'd3, 1);
      press_key(4'd4, 1); press_key(4'hA, 2);
      press_both();

      // zero preset and open door block start; reset in the middle of cooking
      press_key(4'd0, 1); press_start(1);
      press_key(4'd5, 1);
      door_closed = 1'b0; press_start(1);
      door_closed = 1'b1; cycles(2);
      press_start(1);
      cycles(12);
      async_reset_check();

      // stop in DONE, stop in PAUSE
      press_key(4'd2, 1); press_start(1); cycles(5);
      pulse_tz(2); cycles(5); press_stop(1);
      press_key(4'd9, 1); press_start(1); cycles(4);
      press_stop(1); cycles(3); press_stop(1);

      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: press_key(4'($urandom_range(0, 11)), $urandom_range(1, 3));
            3, 9:    press_start($urandom_range(1, 3));
            4:       press_stop($urandom_range(1, 3));
            5: begin
               door_closed = 1'b0; cycles($urandom_range(1, 6)); door_closed = 1'b1;
            end
            6:       pulse_tz($urandom_range(1, 3));
            7:       cycles($urandom_range(1, 25));
            default: press_both();
         endcase
      end

      cycles(5);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
